// File: rtl/sn_stream_decoder.sv
// Stochastic bitstream decoder: counts ones over a window of 2**WIN_LOG2 valid bits.
// Define SN_DEC_BIPOLAR_EN for a bipolar (2*ones - N) signed result; the default build is unipolar.
module sn_stream_decoder #(
  parameter int WIN_LOG2 = 3,
`ifdef SN_DEC_BIPOLAR_EN
  localparam int RES_W = WIN_LOG2 + 2
`else
  localparam int RES_W = WIN_LOG2 + 1
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             sn_bit,
  input  logic             sn_valid,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int N = 1 << WIN_LOG2;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [WIN_LOG2-1:0] bit_cnt;
  logic [WIN_LOG2:0]   ones_cnt;
  logic [WIN_LOG2:0]   total;
  logic [RES_W-1:0]    total_res;
  logic                win_end;
  logic                slot_free;

  // The bit sampled on the closing cycle is folded into the total directly.
  assign total     = ones_cnt + {{WIN_LOG2{1'b0}}, sn_bit};
  assign win_end   = (state == ACCUM) && sn_valid && !start
                     && (bit_cnt == WIN_LOG2'(N - 1));
  assign slot_free = !result_valid || result_ready;
  assign busy      = (state == ACCUM);

`ifdef SN_DEC_BIPOLAR_EN
  // 2*ones fits in RES_W unsigned bits; subtracting N modulo 2**RES_W gives two's complement.
  assign total_res = {total, 1'b0} - RES_W'(N);
`else
  assign total_res = total;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (start) begin
      next_state = ACCUM;
    end else if (win_end) begin
      next_state = cont ? ACCUM : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (start || win_end) begin
      bit_cnt  <= '0;
      ones_cnt <= '0;
    end else if (state == ACCUM && sn_valid) begin
      bit_cnt  <= bit_cnt + WIN_LOG2'(1);
      ones_cnt <= total;
    end
  end

  // Single-entry output slot; a window closing on a full slot is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (win_end && slot_free) begin
        result       <= total_res;
        result_valid <= 1'b1;
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end

      if (start) begin
        overrun <= 1'b0;
      end else if (win_end && !slot_free) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
